// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch request controller with req/gnt handshake,
// stall support, queued redirects while a request is outstanding, and misaligned-target trap.
module pc_fetch_ctrl #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          INC          = 4,
    parameter int          ALIGN_BITS   = 2,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic            fetch_valid_o,
    output logic            fetch_kill_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] bad_addr_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_PEND  = 2'd2,
        S_STALL = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   pend_q, pend_d;
    logic [XLEN-1:0]   bad_addr_q, bad_addr_d;
    logic              valid_q, valid_d;
    logic              kill_q, kill_d;
    logic              mis_q, mis_d;
    logic              tgt_misaligned;
    logic [XLEN-1:0]   eff_target;
    logic [XLEN-1:0]   pc_inc;

    generate
        if (ALIGN_BITS > 0) begin : g_align_chk
            assign tgt_misaligned = |redirect_target_i[ALIGN_BITS-1:0];
        end else begin : g_no_align_chk
            assign tgt_misaligned = 1'b0;
        end
    endgenerate

    // A misaligned target is replaced by the trap vector before any queueing or PC update.
    assign eff_target = tgt_misaligned ? XLEN'(TRAP_VECTOR) : redirect_target_i;
    assign pc_inc     = pc_q + XLEN'(INC);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = stall_i ? S_STALL : S_REQ;
            S_REQ: begin
                if (imem_gnt_i)      state_d = stall_i ? S_STALL : S_REQ;
                else if (redirect_i) state_d = S_PEND;
            end
            S_PEND: begin
                if (imem_gnt_i) state_d = stall_i ? S_STALL : S_REQ;
            end
            S_STALL: state_d = stall_i ? S_STALL : S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req_o = 1'b0;
        if (state_q == S_REQ || state_q == S_PEND) begin
            imem_req_o = 1'b1;
        end
    end

    // Datapath next-state
    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        bad_addr_d = bad_addr_q;
        valid_d    = 1'b0;
        kill_d     = 1'b0;
        mis_d      = 1'b0;
        if (redirect_i && tgt_misaligned) begin
            mis_d      = 1'b1;
            bad_addr_d = redirect_target_i;
        end
        case (state_q)
            S_REQ: begin
                if (imem_gnt_i) begin
                    pc_d    = redirect_i ? eff_target : pc_inc;
                    valid_d = ~redirect_i;
                    kill_d  = redirect_i;
                end else if (redirect_i) begin
                    pend_d = eff_target;
                end
            end
            S_PEND: begin
                if (imem_gnt_i) begin
                    pc_d   = redirect_i ? eff_target : pend_q;
                    kill_d = 1'b1;
                end else if (redirect_i) begin
                    pend_d = eff_target;
                end
            end
            default: begin
                // Nothing outstanding: a redirect lands on the PC directly.
                if (redirect_i) pc_d = eff_target;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= XLEN'(RESET_VECTOR);
            pend_q     <= '0;
            bad_addr_q <= '0;
            valid_q    <= 1'b0;
            kill_q     <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            bad_addr_q <= bad_addr_d;
            valid_q    <= valid_d;
            kill_q     <= kill_d;
            mis_q      <= mis_d;
        end
    end

    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign pc_plus_o     = pc_inc;
    assign fetch_valid_o = valid_q;
    assign fetch_kill_o  = kill_q;
    assign misalign_o    = mis_q;
    assign bad_addr_o    = bad_addr_q;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Parametrised program-counter and fetch-request controller; successor to the single-cycle PC register.
- Generates the instruction-memory request address with a req/gnt handshake, and supports stalls and redirects from branch/jump resolution.
- Redirects that arrive while a request is outstanding are queued, and misaligned targets are trapped.
- Sits between the execute stage (redirect source) and the instruction memory port.

Parameters:
XLEN, 32, width of PC and all address ports
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
INC, 4, PC increment per accepted fetch
ALIGN_BITS, 2, target must have its ALIGN_BITS LSBs zero (1 for compressed ISA)
TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned redirect

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
stall_i  in  1  hold fetch (decode/back-pressure)
redirect_i  in  1  take redirect_target_i (branch taken / jump)
redirect_target_i  in  XLEN  redirect target (ALU result)
imem_req_o  out  1  fetch request valid
imem_addr_o  out  XLEN  fetch address (= pc_o)
imem_gnt_i  in  1  memory accepts request this cycle
pc_o  out  XLEN  current PC
pc_plus_o  out  XLEN  pc_o + INC, combinational, modulo 2^XLEN
fetch_valid_o  out  1  one-cycle pulse: a request was granted for the live path
fetch_kill_o  out  1  one-cycle pulse: a granted fetch belongs to a squashed path
misalign_o  out  1  one-cycle pulse: misaligned redirect trapped
bad_addr_o  out  XLEN  last misaligned target (holds until next trap)

Behaviour:
- Interface decisions: one clock, clk; reset rst, synchronous, active-high. All state updates on posedge clk.
- Reset values:
  - pc_o = RESET_VECTOR; state = S_IDLE.
  - imem_req_o, fetch_valid_o, fetch_kill_o and misalign_o = 0.
  - bad_addr_o = 0; pending target = 0.
  - rst overrides every other input in the same cycle.
- States:
  - S_IDLE: one cycle after reset, req=0. Next state is S_REQ, or S_STALL if stall_i.
  - S_REQ: req=1, addr=pc_o.
  - S_PEND: req=1 on the old address; a redirect is queued.
  - S_STALL: req=0.
- Handshake:
  - Once imem_req_o=1, imem_addr_o and imem_req_o must not change until the cycle imem_gnt_i=1. No retraction, even if stall_i rises.
  - gnt is ignored when req=0.
- S_REQ, gnt=1, no redirect: fetch_valid_o=1 next cycle, pc<=pc+INC. Go to S_STALL if stall_i, else stay in S_REQ (back-to-back fetch, one per cycle).
- S_REQ, gnt=1, redirect_i=1 in the same cycle: the granted fetch is squashed (fetch_kill_o=1, fetch_valid_o=0) and pc<=target. Next state as above.
- S_REQ, gnt=0, redirect_i=1: pending<=target, go to S_PEND. pc is unchanged.
- S_PEND:
  - A further redirect overwrites pending; the latest wins.
  - On gnt: fetch_kill_o=1, pc<=pending, or pc<=redirect_target_i if a redirect arrives in the gnt cycle. Then go to S_STALL/S_REQ per stall_i.
- S_STALL:
  - redirect_i updates pc immediately, with no kill since nothing is outstanding.
  - Leave to S_REQ in the cycle after stall_i=0.
- Misalignment check on every redirect target, i.e. target[ALIGN_BITS-1:0] != 0:
  - The target is replaced by TRAP_VECTOR; misalign_o=1 for one cycle; bad_addr_o<=target.
  - Queueing/kill rules apply as for an aligned redirect.
  - When ALIGN_BITS=0, no check is performed.
- Wrap-around: pc+INC wraps at 2^XLEN with no flag.
- Reset mid-request: the outstanding request is abandoned (req=0 next cycle) and the pending redirect is discarded.
- Pulses (fetch_valid_o, fetch_kill_o, misalign_o) are registered, asserted in the cycle after the triggering edge, and high for exactly one cycle.

Test Plan:
- Reset then gnt tied 1, no stall:
  - Cycle 1: req=0.
  - Then addr sequence 0x0, 0x4, 0x8, 0xC, with fetch_valid_o pulsing every cycle.
- gnt held 0 for 3 cycles at addr 0x8 with redirect_i=1 target 0x40 on cycle 1, then target 0x80 on cycle 2:
  - addr stays 0x8 with req=1 throughout.
  - On gnt: fetch_kill_o=1; next addr 0x80.
- Redirect to 0x42 (ALIGN_BITS=2) in S_REQ with gnt=1: misalign_o=1, bad_addr_o=0x42, pc_o=0x100, fetch_kill_o=1.
- stall_i=1 while req pending with gnt=0: req and addr are held. On gnt, req drops to 0 until stall_i falls; a redirect to 0x200 during the stall gives the first post-stall addr 0x200, with no kill.
- pc_o=0xFFFF_FFFC with gnt: next pc_o=0x0, pc_plus_o=0x4.
- rst asserted in S_PEND (pending 0x40): next cycle req=0, pc_o=RESET_VECTOR; after release, the first fetch is at RESET_VECTOR, not 0x40.
